// File: rtl/wrq_pkg.sv
// Shared constants for the RAH write request queue: default build sizes and FSM state codes.
package wrq_pkg;

    localparam int unsigned WRQ_TOTAL_APPS   = 8;
    localparam int unsigned WRQ_APP_ID_WIDTH = 3;
    localparam int unsigned WRQ_DATA_WIDTH   = 48;
    localparam int unsigned WRQ_LEN_WIDTH    = 16;

    typedef logic [1:0] wrq_state_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_DROP    = 2'd2;

endpackage

// File: rtl/wrq_if.sv
// Link-side word stream plus per-app write-queue strobes of the write request queue.
interface wrq_if
    import wrq_pkg::*;
#(
    parameter int unsigned TOTAL_APPS   = WRQ_TOTAL_APPS,
    parameter int unsigned APP_ID_WIDTH = WRQ_APP_ID_WIDTH,
    parameter int unsigned DATA_WIDTH   = WRQ_DATA_WIDTH
);

    // Handshake: a word moves on a rising clk edge where in_valid && in_ready are both high.
    // in_data must hold while in_valid is high and in_ready is low; in_ready may depend
    // combinationally on data_queue_full but never on in_valid.
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [TOTAL_APPS-1:0]   data_queue_full;
    logic [TOTAL_APPS-1:0]   wr_en;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [APP_ID_WIDTH-1:0] app_id;
    logic                    write_done;
    logic                    bad_app;
    logic                    busy;
    wrq_state_t              state;

    modport master (
        output in_data, in_valid, data_queue_full,
        input  in_ready, wr_en, wr_data, app_id, write_done, bad_app, busy, state
    );

    modport slave (
        input  in_data, in_valid, data_queue_full,
        output in_ready, wr_en, wr_data, app_id, write_done, bad_app, busy, state
    );

endinterface

// File: rtl/wrq.sv
// Write request queue: decodes frame headers from the link and steers payload words
// into the addressed app's write queue, dropping frames for apps that do not exist.
module wrq
    import wrq_pkg::*;
#(
    parameter int unsigned TOTAL_APPS   = WRQ_TOTAL_APPS,
    parameter int unsigned APP_ID_WIDTH = WRQ_APP_ID_WIDTH,
    parameter int unsigned DATA_WIDTH   = WRQ_DATA_WIDTH,
    parameter int unsigned LEN_WIDTH    = WRQ_LEN_WIDTH
) (
    input logic  clk,
    input logic  rst_n,
    wrq_if.slave bus
);

    localparam logic [APP_ID_WIDTH:0] NUM_APPS = (APP_ID_WIDTH + 1)'(TOTAL_APPS);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [TOTAL_APPS-1:0] ONE_HOT0 = TOTAL_APPS'(1);

    wrq_state_t              state;
    logic [LEN_WIDTH-1:0]    remaining;
    logic [APP_ID_WIDTH-1:0] app_id_q;
    logic [TOTAL_APPS-1:0]   wr_en_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic                    write_done_q;
    logic                    bad_app_q;
    logic                    busy_q;

    logic                    ready;
    logic                    accept;
    logic                    target_full;
    logic                    hdr_bad;
    logic [APP_ID_WIDTH-1:0] hdr_app;
    logic [LEN_WIDTH-1:0]    hdr_len;
    logic [TOTAL_APPS-1:0]   app_onehot;

    assign hdr_app    = bus.in_data[APP_ID_WIDTH-1:0];
    assign hdr_len    = bus.in_data[APP_ID_WIDTH+LEN_WIDTH-1:APP_ID_WIDTH];
    assign hdr_bad    = ({1'b0, hdr_app} >= NUM_APPS);
    assign app_onehot = ONE_HOT0 << app_id_q;

    // PAYLOAD is only entered for a valid app id; the guard keeps the index in range.
    assign target_full = ({1'b0, app_id_q} < NUM_APPS) ? bus.data_queue_full[app_id_q] : 1'b1;

    always_comb begin
        ready = 1'b1;
        case (state)
            ST_PAYLOAD: ready = !target_full;
            default:    ready = 1'b1;
        endcase
    end

    assign accept = bus.in_valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            remaining    <= '0;
            app_id_q     <= '0;
            wr_en_q      <= '0;
            wr_data_q    <= '0;
            write_done_q <= 1'b0;
            bad_app_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            wr_en_q      <= '0;
            write_done_q <= 1'b0;
            bad_app_q    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        app_id_q  <= hdr_app;
                        remaining <= hdr_len;
                        if (hdr_bad) begin
                            bad_app_q <= 1'b1;
                            if (hdr_len != '0) begin
                                state <= ST_DROP;
                            end
                        end else if (hdr_len != '0) begin
                            state  <= ST_PAYLOAD;
                            busy_q <= 1'b1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        wr_data_q <= bus.in_data;
                        wr_en_q   <= app_onehot;
                        remaining <= remaining - LEN_ONE;
                        // Last beat: the done pulse rides with this write, and the next word is a header.
                        if (remaining == LEN_ONE) begin
                            write_done_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state        <= ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (accept) begin
                        remaining <= remaining - LEN_ONE;
                        if (remaining == LEN_ONE) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = ready;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.app_id     = app_id_q;
    assign bus.write_done = write_done_q;
    assign bus.bad_app    = bad_app_q;
    assign bus.busy       = busy_q;
    assign bus.state      = state;

endmodule

// File: tb/tb_wrq.sv
// Randomized self-checking bench for wrq: frames are described up front as a list of
// expected beats, and every cycle's outputs are compared against that frame-level model.
module tb_wrq;
    import wrq_pkg::*;

    localparam int unsigned NA = 7;
    localparam int unsigned AW = 3;
    localparam int unsigned DW = 48;
    localparam int unsigned LW = 16;
    localparam int unsigned EW = DW + NA + 1;

    localparam int K_HDR_GO  = 0;
    localparam int K_HDR_BAD = 1;
    localparam int K_HDR_NOP = 2;
    localparam int K_WRITE   = 3;
    localparam int K_DROP    = 4;

    typedef struct {
        int            kind;
        int            app;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    wrq_if #(.TOTAL_APPS(NA), .APP_ID_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wrq #(
        .TOTAL_APPS(NA),
        .APP_ID_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LEN_WIDTH(LW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    beat_t           beat_q[$];
    logic [EW-1:0]   exp_q[$];
    logic [DW-1:0]   frame_w[$];
    logic            mon_en = 1'b0;
    logic            model_busy = 1'b0;
    logic            exp_bad = 1'b0;
    int              exp_app = 0;
    int              cur_app = 0;
    logic            rand_full = 1'b0;
    logic            gap_en = 1'b0;

    always @(negedge clk) begin
        beat_t         b;
        logic [EW-1:0] e;
        logic [NA-1:0] oh;
        logic          exp_ready;
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_en", 64'(bus.wr_en), 64'(e[DW+NA-1:DW]));
                check("wr_data", 64'(bus.wr_data), 64'(e[DW-1:0]));
                check("write_done", 64'(bus.write_done), 64'(e[EW-1]));
            end else begin
                check("wr_en_idle", 64'(bus.wr_en), 64'd0);
                check("write_done_idle", 64'(bus.write_done), 64'd0);
            end
            check("onehot", 64'($countones(bus.wr_en) <= 1), 64'd1);
            check("bad_app", 64'(bus.bad_app), 64'(exp_bad));
            check("busy", 64'(bus.busy), 64'(model_busy));
            check("app_id", 64'(bus.app_id), 64'(exp_app));
            exp_ready = model_busy ? !bus.data_queue_full[cur_app] : 1'b1;
            check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
            exp_bad = 1'b0;

            if (bus.in_valid && bus.in_ready) begin
                if (beat_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    b = beat_q.pop_front();
                    check("beat_data", 64'(bus.in_data), 64'(b.data));
                    case (b.kind)
                        K_HDR_GO: begin
                            model_busy = 1'b1;
                            cur_app    = b.app;
                            exp_app    = b.app;
                        end
                        K_HDR_BAD: begin
                            exp_bad = 1'b1;
                            exp_app = b.app;
                        end
                        K_HDR_NOP: exp_app = b.app;
                        K_WRITE: begin
                            oh = NA'(1) << b.app;
                            exp_q.push_back({b.last, oh, b.data});
                            if (b.last) model_busy = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Random almost-full noise on all queues while enabled.
    always @(posedge clk) begin
        #1;
        if (rand_full) bus.data_queue_full = NA'($urandom) & NA'($urandom);
    end

    // ---------------- driver tasks ----------------
    task automatic build_frame(input int app, input int len);
        logic [DW-1:0] h;
        beat_t         b;
        frame_w.delete();
        h = {$urandom, $urandom};
        h[AW-1:0] = AW'(app);
        h[AW+LW-1:AW] = LW'(len);
        frame_w.push_back(h);
        b.app = app; b.last = 1'b0; b.data = h;
        if (app >= int'(NA))  b.kind = K_HDR_BAD;
        else if (len == 0)    b.kind = K_HDR_NOP;
        else                  b.kind = K_HDR_GO;
        beat_q.push_back(b);
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom, $urandom};
            b.kind = (app >= int'(NA)) ? K_DROP : K_WRITE;
            b.last = (i == len - 1);
            frame_w.push_back(b.data);
            beat_q.push_back(b);
        end
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 2000) begin
                check("accept_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (gap_en && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send_frame(input int app, input int len);
        logic [DW-1:0] words[$];
        build_frame(app, len);
        words = frame_w;
        foreach (words[i]) send_word(words[i]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, 64'(bus.wr_en), 64'd0);
        check({tag, "_wr_data"}, 64'(bus.wr_data), 64'd0);
        check({tag, "_app_id"}, 64'(bus.app_id), 64'd0);
        check({tag, "_write_done"}, 64'(bus.write_done), 64'd0);
        check({tag, "_bad_app"}, 64'(bus.bad_app), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        repeat (2) @(posedge clk);
        beat_q.delete();
        exp_q.delete();
        model_busy = 1'b0;
        exp_bad    = 1'b0;
        exp_app    = 0;
        cur_app    = 0;
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [DW-1:0] words[$];
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.data_queue_full = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_state", 64'(bus.state), 64'(ST_IDLE));
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Basic back-to-back frame.
        send_frame(2, 3);

        // Mid-frame stall on the target app, while a non-target full is ignored.
        build_frame(1, 4);
        words = frame_w;
        send_word(words[0]);
        send_word(words[1]);
        send_word(words[2]);
        bus.data_queue_full = 7'b010_0010;
        bus.in_valid = 1'b1;
        bus.in_data  = words[3];
        repeat (2) begin
            @(negedge clk);
            check("stall_ready", 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        bus.data_queue_full = 7'b010_0000;
        send_word(words[3]);
        send_word(words[4]);
        bus.data_queue_full = '0;

        // Nonexistent app is dropped, then a normal one-word frame.
        send_frame(7, 2);
        send_frame(0, 1);
        send_frame(7, 0);

        // Zero-length header followed by a one-word frame to the same app.
        send_frame(3, 0);
        send_frame(3, 1);

        // Reset in the middle of a frame, then a fresh header.
        build_frame(1, 5);
        words = frame_w;
        send_word(words[0]);
        send_word(words[1]);
        @(negedge clk);
        apply_reset();
        send_frame(4, 1);

        // Two frames with valid held high.
        send_frame(0, 2);
        send_frame(6, 2);

        // Randomized traffic with gaps and full noise.
        gap_en    = 1'b1;
        rand_full = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
            send_frame(int'($urandom_range(0, 7)), len);
        end
        send_frame(5, 200);
        send_frame(7, 30);
        rand_full = 1'b0;
        gap_en    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.data_queue_full = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("beats_left", 64'(beat_q.size()), 64'd0);
        check("writes_left", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
